// File: rtl/add8_share_ctrl.sv
// Byte-serial adder shared by NREQ requesters: round-robin grant, one 8-bit add slice
// reused for NBYTES cycles, then a held response. Optional subtract mode: ADD8_SHARE_CTRL_SUB_EN.
`timescale 1ns/1ps
module add8_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4,
  localparam int W     = 8 * NBYTES,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
`ifdef ADD8_SHARE_CTRL_SUB_EN
  input  logic [NREQ-1:0]     req_sub,
`endif
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_co
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0]  LAST_BYTE = IW'(NBYTES - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]     state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   sum_reg;
  logic [IW-1:0]  byte_idx_reg;
  logic           carry_reg;
  logic           co_reg;
  logic           sub_reg;

  logic [IDW-1:0] cand_idx [NREQ];
  logic [W-1:0]   a_slice  [NREQ];
  logic [W-1:0]   b_slice  [NREQ];
  logic [7:0]     a_byte   [NBYTES];
  logic [7:0]     b_byte   [NBYTES];

  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           grant_fire;
  logic           sub_sel;
  logic [7:0]     b_eff;
  logic [8:0]     slice_sum;

`ifdef ADD8_SHARE_CTRL_SUB_EN
  assign sub_sel = req_sub[grant_idx];
`else
  assign sub_sel = 1'b0;
`endif

  // Candidate i is the requester i places above ptr, wrapping modulo NREQ.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] wrap_sum;
      assign wrap_sum      = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi]  = (wrap_sum >= NREQ_W) ? IDW'(wrap_sum - NREQ_W) : wrap_sum[IDW-1:0];
      assign a_slice[gi]   = req_a[gi*W +: W];
      assign b_slice[gi]   = req_b[gi*W +: W];
      assign req_ready[gi] = grant_fire && (grant_idx == IDW'(gi));
    end
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign a_byte[gi] = a_reg[gi*8 +: 8];
      assign b_byte[gi] = b_reg[gi*8 +: 8];
    end
  endgenerate

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[cand_idx[i]]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  // Gated by rst_n so no accept strobe escapes while reset is held.
  assign grant_fire = rst_n && (state_reg == ST_IDLE) && grant_any;

  // The single shared add slice; subtract inverts B and seeds carry with 1.
  assign b_eff     = b_byte[byte_idx_reg] ^ {8{sub_reg}};
  assign slice_sum = {1'b0, a_byte[byte_idx_reg]} + {1'b0, b_eff} + {8'd0, carry_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      id_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      byte_idx_reg <= '0;
      carry_reg    <= 1'b0;
      co_reg       <= 1'b0;
      sub_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            a_reg        <= a_slice[grant_idx];
            b_reg        <= b_slice[grant_idx];
            id_reg       <= grant_idx;
            sub_reg      <= sub_sel;
            carry_reg    <= sub_sel;
            byte_idx_reg <= '0;
            state_reg    <= ST_ADD;
          end
        end
        ST_ADD: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (byte_idx_reg == IW'(k)) sum_reg[k*8 +: 8] <= slice_sum[7:0];
          end
          carry_reg <= slice_sum[8];
          if (byte_idx_reg == LAST_BYTE) begin
            co_reg       <= slice_sum[8];
            byte_idx_reg <= '0;
            state_reg    <= ST_RESP;
          end else begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            ptr_reg   <= (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_id    = id_reg;
  assign rsp_sum   = sum_reg;
  assign rsp_co    = co_reg;

endmodule

// File: tb/tb_add8_share_ctrl.sv
// Directed bench for add8_share_ctrl (NREQ=4, NBYTES=4); subtract vectors run only
// when ADD8_SHARE_CTRL_SUB_EN is defined.
`timescale 1ns/1ps
module tb_add8_share_ctrl;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_co;
`ifdef ADD8_SHARE_CTRL_SUB_EN
  logic [3:0]   req_sub;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  add8_share_ctrl #(.NREQ(4), .NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
`ifdef ADD8_SHARE_CTRL_SUB_EN
    .req_sub   (req_sub),
`endif
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called one delta after the grant edge; expects rsp_valid after exactly 4 more edges.
  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
  endtask

  task automatic set_slice(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_sum, input logic exp_co, input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    req_valid = onehot;
`ifdef ADD8_SHARE_CTRL_SUB_EN
    req_sub = sub ? onehot : 4'b0000;
`endif
    set_slice(idx, a, b);
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(onehot));
    @(posedge clk); #1;
    req_valid = '0;
    check({tag, "_ready_drop"}, 64'(req_ready), 64'd0);
    wait_rsp(tag);
    check({tag, "_sum"}, 64'(rsp_sum), 64'(exp_sum));
    check({tag, "_co"},  64'(rsp_co),  64'(exp_co));
    check({tag, "_id"},  64'(rsp_id),  64'(idx));
    $display("[TB] %s id=%0d a=%h b=%h sub=%0d sum=%h co=%0d", tag, rsp_id, a, b, sub, rsp_sum, rsp_co);
    @(posedge clk); #1;
    check({tag, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  logic [31:0] rr_sum [4];
  logic        rr_co  [4];
  logic [1:0]  rr_ids [5];

  initial begin
    int cyc;
    int last_cyc;
    int nrsp;
    logic seen;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef ADD8_SHARE_CTRL_SUB_EN
    req_sub   = '0;
`endif

    // Reset state, with requests pending that must not be accepted.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    check("rst_sum",   64'(rsp_sum),   64'd0);
    check("rst_co",    64'(rsp_co),    64'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single ops and carry ripple; first one grants on the first edge after reset.
    run_op(0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, "single");
    run_op(1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, "top_carry");
    run_op(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "ripple_all");
    run_op(3, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, "ripple_b0");

    // Round robin with all requesters valid, starting from ptr=0.
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    set_slice(0, 32'h00000001, 32'h00000002); rr_sum[0] = 32'h00000003; rr_co[0] = 1'b0;
    set_slice(1, 32'h00000010, 32'h00000020); rr_sum[1] = 32'h00000030; rr_co[1] = 1'b0;
    set_slice(2, 32'h00FF0000, 32'h00010000); rr_sum[2] = 32'h01000000; rr_co[2] = 1'b0;
    set_slice(3, 32'hFFFFFFFF, 32'hFFFFFFFF); rr_sum[3] = 32'hFFFFFFFE; rr_co[3] = 1'b1;
    rr_ids[0] = 2'd0; rr_ids[1] = 2'd1; rr_ids[2] = 2'd2; rr_ids[3] = 2'd3; rr_ids[4] = 2'd0;
    req_valid = 4'hF;
    rst_n = 1'b1;
    cyc = 0; last_cyc = 0; nrsp = 0;
    while (nrsp < 5 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid === 1'b1) begin
        check("rr_id",  64'(rsp_id),  64'(rr_ids[nrsp]));
        check("rr_sum", 64'(rsp_sum), 64'(rr_sum[rr_ids[nrsp]]));
        check("rr_co",  64'(rsp_co),  64'(rr_co[rr_ids[nrsp]]));
        if (nrsp > 0) check("rr_spacing", 64'(cyc - last_cyc), 64'd6);
        $display("[TB] rr id=%0d sum=%h co=%0d cycle=%0d", rsp_id, rsp_sum, rsp_co, cyc);
        last_cyc = cyc;
        nrsp++;
      end
    end
    check("rr_count", 64'(nrsp), 64'd5);
    req_valid = '0;
    @(posedge clk); #1;

    // Back-pressure: response held while req1 waits.
    rsp_ready = 1'b0;
    set_slice(0, 32'h00000005, 32'h00000007);
    req_valid = 4'b0001;
    #1;
    check("hold_grant0", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    set_slice(1, 32'h7FFFFFFF, 32'h00000001);
    req_valid = 4'b0010;
    wait_rsp("hold_first");
    check("hold_first_sum", 64'(rsp_sum), 64'h0000000C);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_sum",   64'(rsp_sum),   64'h0000000C);
      check("hold_id",    64'(rsp_id),    64'd0);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    $display("[TB] hold id=%0d sum=%h released after 10 cycles", rsp_id, rsp_sum);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_grant1", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("hold_second");
    check("hold_second_sum", 64'(rsp_sum), 64'h80000000);
    check("hold_second_co",  64'(rsp_co),  64'd0);
    check("hold_second_id",  64'(rsp_id),  64'd1);
    $display("[TB] hold2 id=%0d sum=%h co=%0d", rsp_id, rsp_sum, rsp_co);
    @(posedge clk); #1;

    // Reset during ADD byte 2 (ptr is 2 beforehand).
    set_slice(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    req_valid = 4'b1000;
    #1;
    check("mid_grant3", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_id",    64'(rsp_id),    64'd0);
    check("mid_rst_sum",   64'(rsp_sum),   64'd0);
    check("mid_rst_co",    64'(rsp_co),    64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    check("mid_no_rsp", 64'(seen), 64'd0);
    set_slice(0, 32'h0F0F0F0F, 32'hF0F0F0F1);
    req_valid = 4'hF;
    #1;
    check("mid_fresh_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("mid_fresh");
    check("mid_fresh_id",  64'(rsp_id),  64'd0);
    check("mid_fresh_sum", 64'(rsp_sum), 64'h00000000);
    check("mid_fresh_co",  64'(rsp_co),  64'd1);
    $display("[TB] fresh id=%0d sum=%h co=%0d", rsp_id, rsp_sum, rsp_co);
    @(posedge clk); #1;

`ifdef ADD8_SHARE_CTRL_SUB_EN
    run_op(1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, "sub_borrow");
    run_op(2, 32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, "sub_pos");
    run_op(3, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, "sub_equal");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/add8_share_ctrl.md
ADD8_SHARE_CTRL -- requirements
Module: add8_share_ctrl

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes; W = 8*NBYTES.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ, per-requester operation request.
REQ-006 The block SHALL have port req_ready, output, NREQ, per-requester accept strobe.
REQ-007 The block SHALL have port req_a, input, NREQ*W, per-requester operand A; slice i is bits [i*W +: W].
REQ-008 The block SHALL have port req_b, input, NREQ*W, per-requester operand B, sliced as req_a.
REQ-009 The block SHALL have port rsp_valid, output, 1, result available.
REQ-010 The block SHALL have port rsp_ready, input, 1, result consumer ready.
REQ-011 The block SHALL have port rsp_id, output, clog2(NREQ), index of the requester that owns the result.
REQ-012 The block SHALL have port rsp_sum, output, W, result.
REQ-013 The block SHALL have port rsp_co, output, 1, carry out of the most significant byte.

Function
REQ-014 The block SHALL contain exactly one 8-bit add slice, computing a 9-bit value from a_byte + b_byte + carry_in, time-shared by all requesters.
REQ-015 The FSM SHALL have the states IDLE, ADD and RESP, and SHALL enter IDLE on reset.
REQ-016 In IDLE with any req_valid bit set, the block SHALL grant one requester by round-robin, searching upward from pointer ptr with wrap-around.
REQ-017 In that grant cycle the block SHALL pulse req_ready[g] high for exactly one cycle, latch slices g of req_a and req_b plus g itself, clear the byte index and carry, and move to ADD.
REQ-018 req_ready SHALL be one-hot or zero, and SHALL be high only in the grant cycle.
REQ-019 In ADD, each cycle SHALL process byte k (LSB first): store bits [7:0] of the slice result into result byte k and store bit 8 as the next carry.
REQ-020 After byte NBYTES-1 the block SHALL move to RESP, capturing that byte's final carry as rsp_co.
REQ-021 In RESP, rsp_valid SHALL be 1; rsp_id, rsp_sum and rsp_co SHALL be held stable until the cycle in which rsp_valid and rsp_ready are both high.
REQ-022 On that handshake the block SHALL set ptr to (g+1) mod NREQ and return to IDLE.
REQ-023 Latency: for a grant in cycle T, rsp_valid SHALL first be high in cycle T+1+NBYTES; the minimum issue interval SHALL be NBYTES+2 cycles.
REQ-024 While not in IDLE, req_ready SHALL be 0 and new requests SHALL wait.
REQ-025 Deasserting a req_valid bit before its grant SHALL be legal; the request is withdrawn with no side effect.
REQ-026 rsp_sum SHALL equal (A+B) mod 2^W and rsp_co SHALL equal bit W of A+B; for example 0xFFFFFFFF+0x00000001 gives sum 0x00000000 with co 1.
REQ-027 With every req_valid bit held high, the grant order SHALL be 0,1,...,NREQ-1,0,... so that no requester waits more than NREQ-1 grants.

Reset
REQ-028 While rst_n is low, the block SHALL drive req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_co=0, and hold ptr=0, state=IDLE, byte index=0, carry=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation in progress with no response.
REQ-030 After rst_n deasserts, the first grant SHALL be possible in the first clock edge.

Configuration
REQ-031 With ADD8_SHARE_CTRL_SUB_EN defined, the block SHALL add input port req_sub, width NREQ, latched at grant.
REQ-032 When the latched req_sub bit is set, the block SHALL invert each B byte and use initial carry 1, giving rsp_sum=(A-B) mod 2^W and rsp_co=1 when A>=B (no borrow).
REQ-033 With ADD8_SHARE_CTRL_SUB_EN undefined, req_sub SHALL be absent and every operation SHALL be an add.

Verification
REQ-034 Single request (NREQ=4, NBYTES=4): req0 A=0x12345678, B=0x11111111 -> req_ready[0] pulses once; 5 cycles later rsp_valid=1, rsp_sum=0x23456789, rsp_co=0, rsp_id=0.
REQ-035 Carry ripple across bytes: A=0xFFFFFFFF, B=0x00000001 -> rsp_sum=0x00000000, rsp_co=1; A=0x000000FF, B=0x00000001 -> rsp_sum=0x00000100.
REQ-036 All four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 with responses spaced 6 cycles apart.
REQ-037 rsp_ready held low for 10 cycles with req1 pending -> rsp outputs stable, req_ready stays 0; after rsp_ready rises, req1 is granted in the next cycle.
REQ-038 rst_n pulsed low during ADD byte 2 -> all outputs 0, no response emitted; a fresh request afterwards completes correctly with rsp_id reflecting ptr=0.
REQ-039 With ADD8_SHARE_CTRL_SUB_EN defined: A=0x00000005, B=0x00000007, sub=1 -> rsp_sum=0xFFFFFFFE, rsp_co=0.
